gcd_sched: RTL
==============

# gcd_sched

Round-robin scheduler that shares one pipelined GCD datapath among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the GCD pipeline. It tracks each issued operation with a tag shift register matched to the pipeline latency, then routes each result back to the requester that issued it. It sits between the client blocks and the `gcd` instance, and drives that instance's `start`/`a`/`b` inputs.

## Interface
Parameters:
- `WIDTH`, default 4: operand/result width; must equal the attached gcd `WIDTH`.
- `NREQ`, default 4: number of requesters, 2..8.
- `LAT`, default `1<<WIDTH`: gcd pipeline depth in cycles; must equal the attached gcd stage count.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_a`, `req_b`  in  NREQ*WIDTH: packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NREQ: one-hot, single-cycle result strobe.
- `rsp_data`  out  WIDTH: GCD result, qualified by `rsp_valid`.
- `rsp_err`  out  1: the pipeline did not report done for this tag; qualified by `rsp_valid`.
- `idle`  out  1: no operations outstanding.
- `gcd_start`  out  1: drives gcd `start`.
- `gcd_a`, `gcd_b`  out  WIDTH: drive gcd `a` and `b`.
- `gcd_out`  in  WIDTH: from gcd `out`.
- `gcd_done`  in  1: from gcd `done`.

## Operation
- State per requester: `busy[i]`. At most one outstanding operation per requester.
- Eligible set: `req_valid[i] & ~busy[i]`. The arbiter picks the first eligible index at or after `rr_ptr`, wrapping modulo NREQ.
- `req_ready` is combinational: only the winner's bit is high, and all bits are 0 while `rst` is high.
- On a grant to requester g:
  - `gcd_start` = 1, and `gcd_a`/`gcd_b` carry the operands of g, all in the same cycle. The operands are 0 when there is no grant.
  - At the clock edge, `busy[g]` is set and `rr_ptr` becomes `(g+1) mod NREQ`.
- `rr_ptr` does not change in cycles with no grant.
- Tag pipe: a LAT-entry shift register of `{valid, id}`. It shifts every cycle, and entry 0 loads `{grant, g}`. The last entry is aligned with `gcd_out`/`gcd_done`.
- When the last entry is valid with id k:
  - Next cycle, `rsp_valid[k]` = 1, `rsp_data` = `gcd_out`, `rsp_err` = `~gcd_done`.
  - `busy[k]` clears at the same edge.
- `rsp_data` and `rsp_err` hold their last value when `rsp_valid` is 0.
- `idle` = no `busy` bit set.
- Operands of 0 pass through unchanged. gcd(0,0) returns 0 with no error.

## Timing
- Request accepted in cycle T → operands enter gcd stage 0 at the end of T → `gcd_out` is valid in cycle T+LAT → `rsp_valid` is high in cycle T+LAT+1.
- Total latency is LAT+1 cycles, fixed and independent of the operands.
- Throughput: one issue per cycle across all requesters.
- A requester may be granted again in cycle T+LAT+1, the same cycle its response is high.
- Simultaneous responses cannot occur, because issue is at most one per cycle.
- Reset: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `rr_ptr`=0, `busy`=0, tag pipe cleared, `idle`=1, `gcd_start`=0.
- Reset mid-operation discards all in-flight tags. No responses are produced for them. The gcd instance shares `rst`.
- Dropping `req_valid` without a transfer is allowed; no state changes.

## Structure
- Shared package `gcd_pkg`:
  - `function automatic int gcd_lat(int w)` returning `1<<w`.
  - Parameterised tag struct `{logic valid; logic [$clog2(NREQ)-1:0] id;}` expressed via a width constant.
  - `ID_W` helper.
- One sub-module, `gcd_rr_arb`: NREQ-wide round-robin arbiter with eligible mask in, one-hot grant out, and an internal pointer updated on grant.
- The tag pipe, busy tracking and response register live in `gcd_sched`.

## Test plan
Bench uses WIDTH=4, NREQ=4, LAT=16, with `gcd_sched` wired to a real `gcd` instance.
- Single request, requester 2, a=12, b=8, accepted in cycle T → `rsp_valid`=4'b0100 in T+17, `rsp_data`=4, `rsp_err`=0, `idle`=1 after.
- All four requesters assert valid in the same cycle with (9,6), (7,7), (0,5), (15,1) → grants in order 0,1,2,3 in consecutive cycles. Responses arrive in consecutive cycles with data 3, 7, 5, 1.
- Requester 0 holds `req_valid` continuously → `req_ready[0]` is low from acceptance until the response cycle. It is re-granted in exactly the response cycle, and the other requesters are granted in the gap.
- Requesters 1 and 3 contend repeatedly with `rr_ptr`=2 → grants alternate 3,1,3,1. `rr_ptr` wraps from 3 to 0 correctly.
- Assert `rst` while 3 operations are in flight → no `rsp_valid` occurs afterwards. All outputs take their reset values. The next request after reset completes normally with gcd(10,4)=2.
- Force `gcd_done`=0 on a result cycle → `rsp_err`=1 with the correct `rsp_valid` bit, and `busy` still clears.

Source files
------------

// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD scheduler slice.
//   gcd_lat(w)  : pipeline depth of a gcd instance of operand width w
//   id_w(n)     : bits needed to name one of n requesters (minimum 1)
//   tag_t       : {valid, id} entry of the scheduler tag pipe, sized for
//                 the largest supported requester count
// ---------------------------------------------------------------------------
package gcd_pkg;

   localparam int MAX_NREQ = 8;

   // The gcd datapath unrolls one stage per possible subtraction step.
   function automatic int gcd_lat(int w);
      return 1 << w;
   endfunction

   // A single requester still needs a one-bit id field to keep the types legal.
   function automatic int id_w(int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   localparam int TAG_ID_W = id_w(MAX_NREQ);

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/gcd_sched_if.sv
// ---------------------------------------------------------------------------
// gcd_sched_if
// Bundles the requester handshake, the response strobe and the connection to
// the shared gcd datapath.
//   master : requester/datapath side (drives requests and gcd results)
//   slave  : scheduler side (drives grants, responses and gcd operands)
// ---------------------------------------------------------------------------
interface gcd_sched_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  idle;
   logic                  gcd_start;
   logic [WIDTH-1:0]      gcd_a;
   logic [WIDTH-1:0]      gcd_b;
   logic [WIDTH-1:0]      gcd_out;
   logic                  gcd_done;

   modport master (
      output req_valid, req_a, req_b, gcd_out, gcd_done,
      input  req_ready, rsp_valid, rsp_data, rsp_err, idle,
             gcd_start, gcd_a, gcd_b
   );

   modport slave (
      input  req_valid, req_a, req_b, gcd_out, gcd_done,
      output req_ready, rsp_valid, rsp_data, rsp_err, idle,
             gcd_start, gcd_a, gcd_b
   );
endinterface

// File: rtl/gcd_rr_arb.sv
// ---------------------------------------------------------------------------
// gcd_rr_arb
// Round-robin arbiter. Picks the first eligible index at or after the
// pointer, wrapping modulo NREQ; the pointer moves past the winner only
// when a grant is issued.
//   clk, rst  : clock, synchronous active-high reset
//   eligible  : NREQ request mask
//   grant     : one-hot winner, all zero during reset
//   gnt_any   : a grant is issued this cycle
//   gnt_id    : index of the winner (meaningful when gnt_any)
// ---------------------------------------------------------------------------
module gcd_rr_arb
   import gcd_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = id_w(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] eligible,
   output logic [NREQ-1:0] grant,
   output logic            gnt_any,
   output logic [ID_W-1:0] gnt_id
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] win_id;
   logic            found;

   // Scan outward from the pointer; the wrap is done in ID_W-bit arithmetic,
   // which stays exact because the wrapped index is always below NREQ.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(ptr_q) + i >= NREQ) begin
            cand = ptr_q + ID_W'(i) - ID_W'(NREQ);
         end else begin
            cand = ptr_q + ID_W'(i);
         end
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

   // Grants are suppressed while reset is held so nothing transfers then.
   always_comb begin
      grant   = '0;
      gnt_any = found && !rst;
      gnt_id  = win_id;
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = gnt_any && (win_id == ID_W'(i));
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/gcd_sched.sv
// ---------------------------------------------------------------------------
// gcd_sched
// Shares one pipelined gcd datapath among NREQ requesters. At most one
// operand pair issues per cycle; a tag pipe of depth LAT follows each issue
// so the result leaving the datapath can be steered back to its requester
// one cycle later.
//   clk, rst : clock, synchronous active-high reset (shared with the gcd)
//   bus      : slave side of gcd_sched_if
//              req_valid/req_a/req_b/req_ready : per-requester handshake
//              rsp_valid/rsp_data/rsp_err      : registered result strobe
//              idle                            : nothing outstanding
//              gcd_start/gcd_a/gcd_b           : drive the gcd inputs
//              gcd_out/gcd_done                : gcd results
// ---------------------------------------------------------------------------
module gcd_sched
   import gcd_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int LAT   = gcd_lat(WIDTH)
) (
   input logic        clk,
   input logic        rst,
   gcd_sched_if.slave bus
);

   localparam int ID_W = id_w(NREQ);

   logic [NREQ-1:0]  busy_q, busy_d;
   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  grant;
   logic             gnt_any;
   logic [ID_W-1:0]  gnt_id;
   logic [WIDTH-1:0] op_a, op_b;

   tag_t             tag_q [LAT];
   tag_t             tag_d [LAT];
   tag_t             tag_last;

   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;

   // A requester with an operation in flight is held off until its result
   // has been routed back.
   assign eligible = bus.req_valid & ~busy_q;

   gcd_rr_arb #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
      .grant    (grant),
      .gnt_any  (gnt_any),
      .gnt_id   (gnt_id)
   );

   // Operands of the winner go straight to the datapath; zero otherwise.
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            op_a = bus.req_a[i*WIDTH +: WIDTH];
            op_b = bus.req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.gcd_start = gnt_any;
   assign bus.gcd_a     = op_a;
   assign bus.gcd_b     = op_b;

   // The tag pipe runs in lockstep with the gcd stages, so its last entry
   // describes whatever gcd_out is presenting this cycle.
   always_comb begin
      tag_d[0] = '{valid: gnt_any, id: TAG_ID_W'(gnt_id)};
      for (int i = 1; i < LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   assign tag_last = tag_q[LAT-1];

   // Capture the finished result and retire the owner's busy bit. A grant to
   // the same requester cannot coincide with its retirement because busy
   // masks it out of arbitration until the edge that clears it.
   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      busy_d      = busy_q;
      if (tag_last.valid) begin
         rsp_data_d = bus.gcd_out;
         rsp_err_d  = ~bus.gcd_done;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (tag_last.valid && (tag_last.id == TAG_ID_W'(i))) begin
            rsp_valid_d[i] = 1'b1;
            busy_d[i]      = 1'b0;
         end
      end
      busy_d = busy_d | grant;
   end

   // Reset discards every in-flight tag so no stale responses appear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
         busy_q      <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.idle      = ~|busy_q;

endmodule
